serial_diff_checker: RTL and testbench
======================================

// Module: serial_diff_checker
// PURPOSE
//   Bit-serial word comparator: the receiving end for operands that arrive one bit per
//   cycle, LSB first, instead of as parallel buses.
//   Accepts two WIDTH-bit operands as paired bit streams under a valid/ready handshake.
//   After the last bit it reports diff = OR(a^b), plus the lowest differing bit index and
//   the magnitude relation (unsigned).
//   Sits between a serial link and the ALU compare path.
// PARAMETERS
//   WIDTH   4                 operand width in bits; legal range >= 2
//   IDX_W   $clog2(WIDTH)     width of first_idx; derived, not overridden
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   start      in   1      begin a comparison; sampled only in IDLE
//   bit_valid  in   1      a_bit/b_bit carry a valid operand bit this cycle
//   a_bit      in   1      next bit of operand a, LSB first
//   b_bit      in   1      next bit of operand b, LSB first
//   bit_ready  out  1      block accepts a bit pair this cycle (state == SHIFT)
//   busy       out  1      high in SHIFT and DONE
//   done       out  1      one-cycle pulse; results valid
//   diff       out  1      1 when a != b
//   first_idx  out  IDX_W  lowest bit index where a and b differ; 0 when diff == 0
//   lt         out  1      a < b (unsigned)
//   gt         out  1      a > b (unsigned); lt and gt are never both 1
// BEHAVIOUR
//   Reset: state = IDLE; bit_ready, busy, done, diff, first_idx, lt and gt are all 0.
//     Bit counter and accumulators are cleared.
//   States and transitions:
//     IDLE  -> SHIFT on start. Clears the bit counter and the diff/first_idx/lt/gt accumulators.
//     SHIFT: a bit pair is accepted on a rising edge with bit_valid && bit_ready.
//       Let i be the current count, 0..WIDTH-1. For each accepted pair:
//         a_bit != b_bit and no difference seen yet  -> first_idx <= i
//         a_bit != b_bit                             -> diff <= 1; gt <= a_bit; lt <= b_bit
//           (the later, more significant difference overrides earlier lt/gt)
//         counter <= counter + 1
//       When pair index WIDTH-1 is accepted, the next state is DONE.
//       bit_valid low in SHIFT stalls the block indefinitely; there is no timeout.
//     DONE: done = 1 for exactly one cycle, then IDLE.
//   Latency: done rises one cycle after the edge that accepts the last pair.
//     Minimum start-to-done time is WIDTH+2 cycles.
//   Output hold: diff, first_idx, lt and gt stay stable from DONE until the next start
//     is accepted. They may change during SHIFT and are valid only from the done pulse.
//   start is ignored in SHIFT and DONE; there is no restart mid-operation.
//   bit_valid is ignored in IDLE and DONE; those bits are dropped, not buffered.
//   Reset asserted in any state wins over all other inputs on that edge and aborts the
//     comparison. No done pulse follows.
//   Equal operands: diff = lt = gt = 0 and first_idx = 0.
// STRUCTURE
//   Shared package/header (serial_cmp_defs):
//     state encodings ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2
//     default WIDTH
//   Sub-module bit_diff_cell (combinational):
//     inputs a, b; outputs neq = a^b, agt = a&~b, blt = ~a&b
//     one instance feeds the accumulators
//   Top level: FSM, bit counter of IDX_W+1 bits, accumulator registers, output logic.
// TESTING
//   1. Reset, then a=0100, b=0011 sent LSB first (start, then 4 valid cycles)
//      -> done pulse; diff=1, first_idx=0, gt=1, lt=0.
//   2. a=0110, b=0110 -> diff=0, first_idx=0, lt=0, gt=0; done high exactly 1 cycle.
//   3. a=0001, b=1000 -> diff=1, first_idx=0, lt=1, gt=0 (MSB difference overrides LSB).
//   4. bit_valid dropped for 3 cycles after bit 1 of a=1010, b=1011
//      -> no extra bits consumed; done arrives 3 cycles later; diff=1, first_idx=0, lt=1.
//   5. reset asserted after 2 of 4 bits -> next cycle IDLE, all outputs 0, no done;
//      a fresh start then works normally.
//   6. start held high through SHIFT/DONE and bit_valid pulsed in IDLE
//      -> exactly one comparison per accepted start; results held until the next start.

Source files
------------

// File: rtl/serial_diff_checker_pkg.sv
// serial_diff_checker_pkg: shared state encodings and default operand width
package serial_diff_checker_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/serial_diff_checker_if.sv
// serial_diff_checker_if: bit-stream handshake and compare results
interface serial_diff_checker_if
  import serial_diff_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int IDX_W = $clog2(WIDTH)
);
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic bit_ready;
  logic busy;
  logic done;
  logic diff;
  logic [IDX_W-1:0] first_idx;
  logic lt;
  logic gt;
  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  bit_ready, busy, done, diff, first_idx, lt, gt
  );
  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output bit_ready, busy, done, diff, first_idx, lt, gt
  );
endinterface

// File: rtl/serial_diff_checker_bit_diff_cell.sv
// bit_diff_cell: per-bit inequality and ordering of one operand bit pair
module bit_diff_cell (
  input  logic a,
  input  logic b,
  output logic neq,
  output logic agt,
  output logic blt
);
  assign neq = a ^ b;
  assign agt = a & ~b;
  assign blt = ~a & b;
endmodule

// File: rtl/serial_diff_checker.sv
// serial_diff_checker: LSB-first bit-serial comparator reporting diff, lowest differing index and unsigned order
module serial_diff_checker
  import serial_diff_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic reset,
  serial_diff_checker_if.slave io
);
  localparam int CNT_W = IDX_W + 1;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic diff_q, diff_d, lt_q, lt_d, gt_q, gt_d;
  logic ready_q, busy_q, done_q;
  logic neq, agt, blt, take, last;
  bit_diff_cell u_cell (
    .a(io.a_bit),
    .b(io.b_bit),
    .neq(neq),
    .agt(agt),
    .blt(blt)
  );
  assign take = io.bit_valid && state_q == ST_SHIFT;
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  // later (more significant) differences override lt/gt; first_idx only latches once
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    diff_d = diff_q;
    lt_d = lt_q;
    gt_d = gt_q;
    if (state_q == ST_IDLE && io.start) begin
      state_d = ST_SHIFT;
      cnt_d = '0;
      idx_d = '0;
      diff_d = 1'b0;
      lt_d = 1'b0;
      gt_d = 1'b0;
    end else if (take) begin
      cnt_d = cnt_q + 1'b1;
      diff_d = diff_q | neq;
      lt_d = neq ? blt : lt_q;
      gt_d = neq ? agt : gt_q;
      idx_d = (neq && !diff_q) ? cnt_q[IDX_W-1:0] : idx_q;
      state_d = last ? ST_DONE : ST_SHIFT;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      diff_q <= 1'b0;
      lt_q <= 1'b0;
      gt_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      diff_q <= diff_d;
      lt_q <= lt_d;
      gt_q <= gt_d;
      ready_q <= state_d == ST_SHIFT;
      busy_q <= state_d != ST_IDLE;
      done_q <= state_d == ST_DONE;
    end
  end
  assign io.bit_ready = ready_q;
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.diff = diff_q;
  assign io.first_idx = idx_q;
  assign io.lt = lt_q;
  assign io.gt = gt_q;
endmodule

// File: tb/tb_serial_diff_checker.sv
// tb_serial_diff_checker: directed and randomized comparisons against an arithmetic reference model
module tb_serial_diff_checker;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  serial_diff_checker_if #(.WIDTH(W)) io ();
  serial_diff_checker #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .io(io.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_res(input string tag, input int a, input int b);
    int x;
    int fi;
    x = a ^ b;
    fi = 0;
    for (int i = W - 1; i >= 0; i--) if (x[i]) fi = i;
    chk({tag, "_diff"}, 32'(io.diff), 32'(a != b));
    chk({tag, "_idx"}, 32'(io.first_idx), 32'(fi));
    chk({tag, "_lt"}, 32'(io.lt), 32'(a < b));
    chk({tag, "_gt"}, 32'(io.gt), 32'(a > b));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(io.bit_ready), 0);
    chk({tag, "_busy"}, 32'(io.busy), 0);
    chk({tag, "_done"}, 32'(io.done), 0);
    chk_res(tag, 0, 0);
  endtask
  // mode 0: no stalls, 1: random stalls, 2: 3-cycle stall after bit 1
  task automatic run(input int a, input int b, input int mode, input bit hold);
    int stalls;
    @(negedge clk);
    chk("pre_busy", 32'(io.busy), 0);
    io.start = 1'b1;
    @(negedge clk);
    io.start = hold;
    for (int i = 0; i < W; i++) begin
      stalls = mode == 1 ? int'($urandom_range(0, 2)) : (mode == 2 && i == 2) ? 3 : 0;
      for (int s = 0; s < stalls; s++) begin
        io.bit_valid = 1'b0;
        io.a_bit = 1'($urandom);
        io.b_bit = 1'($urandom);
        @(negedge clk);
        chk("stall_ready", 32'(io.bit_ready), 1);
        chk("stall_done", 32'(io.done), 0);
      end
      chk("ready", 32'(io.bit_ready), 1);
      chk("busy", 32'(io.busy), 1);
      chk("early_done", 32'(io.done), 0);
      io.bit_valid = 1'b1;
      io.a_bit = a[i];
      io.b_bit = b[i];
      @(negedge clk);
    end
    io.bit_valid = hold;
    io.a_bit = 1'($urandom);
    io.b_bit = 1'($urandom);
    chk("done", 32'(io.done), 1);
    chk("done_ready", 32'(io.bit_ready), 0);
    chk("done_busy", 32'(io.busy), 1);
    chk_res("res", a, b);
    @(negedge clk);
    io.bit_valid = 1'b0;
    io.start = 1'b0;
    chk("done_pulse", 32'(io.done), 0);
    chk("post_busy", 32'(io.busy), 0);
    chk_res("hold", a, b);
  endtask
  initial begin
    io.start = 1'b0;
    io.bit_valid = 1'b0;
    io.a_bit = 1'b0;
    io.b_bit = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("after_reset");
    run(4'b0100, 4'b0011, 0, 1'b0);
    run(4'b0110, 4'b0110, 0, 1'b0);
    run(4'b0001, 4'b1000, 0, 1'b0);
    run(4'b1010, 4'b1011, 2, 1'b0);
    // abort after two bits
    @(negedge clk);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      io.bit_valid = 1'b1;
      io.a_bit = 1'b1;
      io.b_bit = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    io.bit_valid = 1'b0;
    chk_zero("abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(io.done), 0);
      chk("abort_idle", 32'(io.busy), 0);
    end
    run(4'b1100, 4'b0101, 0, 1'b0);
    // bits offered in IDLE must be dropped
    for (int i = 0; i < 3; i++) begin
      io.bit_valid = 1'b1;
      io.a_bit = 1'b0;
      io.b_bit = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(io.busy), 0);
      chk("idle_ready", 32'(io.bit_ready), 0);
      chk_res("idle_hold", 4'b1100, 4'b0101);
    end
    io.bit_valid = 1'b0;
    run(4'b0111, 4'b1001, 1, 1'b1);
    run(4'b1111, 4'b1110, 0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      int a;
      int b;
      a = int'($urandom_range(0, (1 << W) - 1));
      b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, (1 << W) - 1));
      run(a, b, 1, 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
